dmem_arbiter: RTL

//  Shares the core's single-port data memory between the rv32i core load/store port and a debug/loader port.

---
 rtl/dmem_arb_pkg.sv | 14 +
 rtl/rr_arb2.sv | 18 +
 rtl/dmem_arbiter.sv | 94 +++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared encodings and defaults for the data-memory arbiter
package dmem_arb_pkg;
    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DBG  = 1'b1
    } owner_t;
    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        LOCKING = 2'd1,
        LOCKED  = 2'd2
    } state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin picker, bit 0 = core, bit 1 = debug
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic [1:0] eligible,
    input  owner_t     last,
    output logic [1:0] gnt,
    output owner_t     owner
);
    logic [1:0] cand;
    assign cand = req & eligible;
    always_comb begin
        owner = (cand == 2'b11) ? ((last == OWN_CORE) ? OWN_DBG : OWN_CORE)
              : (cand[1] ? OWN_DBG : OWN_CORE);
        gnt   = (cand == 2'b00) ? 2'b00 : ((owner == OWN_DBG) ? 2'b10 : 2'b01);
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the core and a debug/loader port,
// round-robin, with a debug lock that drains core loads before acknowledging.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                core_req,
    input  logic                core_we,
    input  logic [ADDR_W-1:0]   core_addr,
    input  logic [DATA_W-1:0]   core_wdata,
    input  logic [DATA_W/8-1:0] core_be,
    output logic                core_gnt,
    output logic                core_rvalid,
    output logic [DATA_W-1:0]   core_rdata,
    input  logic                dbg_req,
    input  logic                dbg_we,
    input  logic [ADDR_W-1:0]   dbg_addr,
    input  logic [DATA_W-1:0]   dbg_wdata,
    input  logic [DATA_W/8-1:0] dbg_be,
    output logic                dbg_gnt,
    output logic                dbg_rvalid,
    output logic [DATA_W-1:0]   dbg_rdata,
    input  logic                dbg_lock,
    output logic                lock_ack,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);
    state_t     state, state_nxt;
    owner_t     last_owner, rd_owner, gnt_owner;
    logic       rd_pend;
    logic [1:0] gnt, eligible;

    rr_arb2 u_arb (
        .req      ({dbg_req, core_req}),
        .eligible (eligible),
        .last     (last_owner),
        .gnt      (gnt),
        .owner    (gnt_owner)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= NORMAL;
        else       state <= state_nxt;
    end

    // Leaving LOCKING only needs the core's read to be gone; a debug read may still be in flight.
    always_comb begin
        state_nxt = (state == NORMAL) ? (dbg_lock ? LOCKING : NORMAL)
                  : !dbg_lock ? NORMAL
                  : (state == LOCKING && (!rd_pend || rd_owner == OWN_DBG)) ? LOCKED
                  : state;
    end

    always_comb begin
        lock_ack = (state == LOCKED) && dbg_lock;
        eligible = {!reset, !reset && state == NORMAL && !dbg_lock};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner <= OWN_DBG;
            rd_owner   <= OWN_CORE;
            rd_pend    <= 1'b0;
        end else begin
            rd_pend <= mem_en && !mem_we;
            if (mem_en) begin
                last_owner <= gnt_owner;
                rd_owner   <= gnt_owner;
            end
        end
    end

    always_comb begin
        core_gnt    = gnt[0];
        dbg_gnt     = gnt[1];
        mem_en      = |gnt;
        mem_we      = gnt[1] ? dbg_we    : (gnt[0] ? core_we    : 1'b0);
        mem_be      = gnt[1] ? dbg_be    : (gnt[0] ? core_be    : '0);
        mem_addr    = gnt[1] ? dbg_addr  : (gnt[0] ? core_addr  : '0);
        mem_wdata   = gnt[1] ? dbg_wdata : (gnt[0] ? core_wdata : '0);
        core_rvalid = rd_pend && rd_owner == OWN_CORE;
        dbg_rvalid  = rd_pend && rd_owner == OWN_DBG;
        core_rdata  = core_rvalid ? mem_rdata : '0;
        dbg_rdata   = dbg_rvalid  ? mem_rdata : '0;
    end
endmodule
